// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline definitions for the ID/EX boundary.
//   ctrl_t       : 19-bit decoder control bundle, MSB first:
//                  alu_op[3:0], mode[1:0], memtoreg, memwrite, alu_src,
//                  regwrite, syscall, signedext, regdst, beq, bne, jr, jmp,
//                  jal, shift
//   ALU_NOP      : ALU opcode carried by an inserted bubble
//   REG_RA       : link register written by jal
//   BUBBLE_CTRL  : control bundle of a bubble (all flags clear, alu_op=NOP)
//   sel_dst()    : destination register selection used at load time
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] mode;
        logic       memtoreg;
        logic       memwrite;
        logic       alu_src;
        logic       regwrite;
        logic       syscall;
        logic       signedext;
        logic       regdst;
        logic       beq;
        logic       bne;
        logic       jr;
        logic       jmp;
        logic       jal;
        logic       shift;
    } ctrl_t;

    localparam int         CTRL_W  = $bits(ctrl_t);
    localparam logic [3:0] ALU_NOP = 4'd13;
    localparam logic [4:0] REG_RA  = 5'd31;

    // alu_op occupies the top four bits; every flag below it is clear.
    localparam ctrl_t BUBBLE_CTRL = ctrl_t'({ALU_NOP, 15'd0});

    // jal links into $ra regardless of the encoded fields; otherwise R-type
    // instructions (regdst) write rd and I-type instructions write rt.
    function automatic logic [4:0] sel_dst(input ctrl_t c,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
        logic [4:0] dst;
        if (c.jal) begin
            dst = REG_RA;
        end else if (c.regdst) begin
            dst = rd;
        end else begin
            dst = rt;
        end
        return dst;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Load-use hazard detection between the instruction held in EX and the one
// currently decoded in ID. Purely combinational.
// Ports:
//   halt_i        : processor halted; hazard is suppressed while halted
//   ex_valid_i    : EX slot holds a real instruction
//   ex_memtoreg_i : EX instruction is a load
//   ex_dst_i      : EX destination register
//   id_valid_i    : ID slot holds a real instruction
//   id_rs_i/rt_i  : ID source register fields
//   load_use_o    : stall request for one cycle (bubble into EX)
// -----------------------------------------------------------------------------
module hazard_detect (
    input  logic       halt_i,
    input  logic       ex_valid_i,
    input  logic       ex_memtoreg_i,
    input  logic [4:0] ex_dst_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    output logic       load_use_o
);

    logic dst_nonzero;
    logic dst_match;

    // $zero is never a real dependency.
    assign dst_nonzero = (ex_dst_i != 5'd0);
    assign dst_match   = (ex_dst_i == id_rs_i) || (ex_dst_i == id_rt_i);

    assign load_use_o = ~halt_i & ex_valid_i & ex_memtoreg_i & dst_nonzero
                      & dst_match & id_valid_i;

endmodule

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register with flush, stall, load-use bubble insertion and a
// sticky syscall halt.
// Configuration macro: ID_EX_BUBBLE_CNT_EN
//   defined   -> bubble_cnt counts inserted bubbles, saturating at all-ones
//   undefined -> bubble_cnt is constant 0 and no counter is built
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   valid_in, ctrl_in     : ID instruction valid and decoded control bundle
//   pc_in, rs_data,
//   rt_data, imm_in       : ID PC, operands and extended immediate (DW bits)
//   rs_addr, rt_addr,
//   rd_addr, shamt        : ID register fields and shift amount
//   stall, flush          : hold / squash of the ID/EX register
//   ex_*                  : registered EX-stage copies; ex_dst is the
//                           resolved write register
//   load_use              : load-use hazard, upstream holds PC and IF/ID
//   halt                  : sticky syscall halt
//   bubble_cnt            : number of inserted bubbles
// Per-cycle priority: reset > halt > flush > stall > load_use > load.
// -----------------------------------------------------------------------------
module id_ex_reg
    import pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    input  ctrl_t         ctrl_in,
    input  logic [DW-1:0] pc_in,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic [DW-1:0] imm_in,
    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    input  logic [4:0]    rd_addr,
    input  logic [4:0]    shamt,
    input  logic          stall,
    input  logic          flush,
    output logic          ex_valid,
    output ctrl_t         ex_ctrl,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rs_addr,
    output logic [4:0]    ex_rt_addr,
    output logic [4:0]    ex_dst,
    output logic [4:0]    ex_shamt,
    output logic          load_use,
    output logic          halt,
    output logic [31:0]   bubble_cnt
);

    logic          ex_valid_q,   ex_valid_d;
    ctrl_t         ex_ctrl_q,    ex_ctrl_d;
    logic [DW-1:0] ex_pc_q,      ex_pc_d;
    logic [DW-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DW-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [DW-1:0] ex_imm_q,     ex_imm_d;
    logic [4:0]    ex_rs_addr_q, ex_rs_addr_d;
    logic [4:0]    ex_rt_addr_q, ex_rt_addr_d;
    logic [4:0]    ex_dst_q,     ex_dst_d;
    logic [4:0]    ex_shamt_q,   ex_shamt_d;
    logic          halt_q,       halt_d;
    logic          load_use_w;

    hazard_detect u_hazard (
        .halt_i        (halt_q),
        .ex_valid_i    (ex_valid_q),
        .ex_memtoreg_i (ex_ctrl_q.memtoreg),
        .ex_dst_i      (ex_dst_q),
        .id_valid_i    (valid_in),
        .id_rs_i       (rs_addr),
        .id_rt_i       (rt_addr),
        .load_use_o    (load_use_w)
    );

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_pc_d      = ex_pc_q;
        ex_rs_data_d = ex_rs_data_q;
        ex_rt_data_d = ex_rt_data_q;
        ex_imm_d     = ex_imm_q;
        ex_rs_addr_d = ex_rs_addr_q;
        ex_rt_addr_d = ex_rt_addr_q;
        ex_dst_d     = ex_dst_q;
        ex_shamt_d   = ex_shamt_q;

        // A syscall only halts once it is a real instruction sitting in EX.
        halt_d = halt_q | (ex_valid_q & ex_ctrl_q.syscall);

        if (halt_q) begin
            // Frozen: flush, stall and new ID contents are all ignored.
        end else if (flush || (!stall && load_use_w)) begin
            ex_valid_d   = 1'b0;
            ex_ctrl_d    = BUBBLE_CTRL;
            ex_pc_d      = '0;
            ex_rs_data_d = '0;
            ex_rt_data_d = '0;
            ex_imm_d     = '0;
            ex_rs_addr_d = '0;
            ex_rt_addr_d = '0;
            ex_dst_d     = '0;
            ex_shamt_d   = '0;
        end else if (stall) begin
            // External hold, including while a load-use hazard is pending.
        end else begin
            ex_valid_d   = valid_in;
            ex_ctrl_d    = ctrl_in;
            ex_pc_d      = pc_in;
            ex_rs_data_d = rs_data;
            ex_rt_data_d = rt_data;
            ex_imm_d     = imm_in;
            ex_rs_addr_d = rs_addr;
            ex_rt_addr_d = rt_addr;
            ex_dst_d     = sel_dst(ctrl_in, rt_addr, rd_addr);
            ex_shamt_d   = shamt;
        end
    end

    // ---- ID/EX register boundary ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= BUBBLE_CTRL;
            ex_pc_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_addr_q <= '0;
            ex_rt_addr_q <= '0;
            ex_dst_q     <= '0;
            ex_shamt_q   <= '0;
            halt_q       <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_pc_q      <= ex_pc_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_addr_q <= ex_rs_addr_d;
            ex_rt_addr_q <= ex_rt_addr_d;
            ex_dst_q     <= ex_dst_d;
            ex_shamt_q   <= ex_shamt_d;
            halt_q       <= halt_d;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic        bubble_ins;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Same condition that selects the bubble branch above.
    assign bubble_ins = ~halt_q & (flush | (~stall & load_use_w));

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_ins && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = '0;
`endif

    assign ex_valid   = ex_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_pc      = ex_pc_q;
    assign ex_rs_data = ex_rs_data_q;
    assign ex_rt_data = ex_rt_data_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rs_addr = ex_rs_addr_q;
    assign ex_rt_addr = ex_rt_addr_q;
    assign ex_dst     = ex_dst_q;
    assign ex_shamt   = ex_shamt_q;
    assign load_use   = load_use_w;
    assign halt       = halt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;
    import pipe_pkg::*;

`ifdef ID_EX_BUBBLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Bubble bundle written out by hand: alu_op=13 in bits [18:15].
    localparam logic [18:0] EXP_BUBBLE = 19'h68000;

    logic        clk = 1'b0;
    logic        rst_n, valid_in, stall, flush;
    ctrl_t       ctrl_in;
    logic [31:0] pc_in, rs_data, rt_data, imm_in;
    logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
    logic        ex_valid;
    ctrl_t       ex_ctrl;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs_addr, ex_rt_addr, ex_dst, ex_shamt;
    logic        load_use, halt;
    logic [31:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ctrl_in(ctrl_in),
        .pc_in(pc_in), .rs_data(rs_data), .rt_data(rt_data), .imm_in(imm_in),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .shamt(shamt),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_dst(ex_dst),
        .ex_shamt(ex_shamt), .load_use(load_use), .halt(halt),
        .bubble_cnt(bubble_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operand data is derived from the PC so every field is distinct.
    task automatic set_instr(input logic v, input logic [18:0] c, input logic [31:0] pc,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        valid_in = v;
        ctrl_in  = ctrl_t'(c);
        pc_in    = pc;
        rs_data  = pc + 32'd1;
        rt_data  = pc + 32'd2;
        imm_in   = pc + 32'd3;
        rs_addr  = rs;
        rt_addr  = rt;
        rd_addr  = rd;
        shamt    = rd ^ 5'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_instr(1'b0, 19'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();
        rst_n = 1'b1;
    endtask

    // Control encodings (bit 12 memtoreg, 10 alu_src, 9 regwrite, 8 syscall,
    // 6 regdst, 1 jal; alu_op in [18:15]).
    localparam logic [18:0] C_ADDI = 19'h28600; // alu_op=5, alu_src, regwrite
    localparam logic [18:0] C_ADD  = 19'h10240; // alu_op=2, regwrite, regdst
    localparam logic [18:0] C_LW   = 19'h01600; // memtoreg, alu_src, regwrite
    localparam logic [18:0] C_JAL  = 19'h00202; // regwrite, jal
    localparam logic [18:0] C_SYS  = 19'h01100; // syscall plus memtoreg

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_instr(1'b1, C_ADDI, 32'hDEAD_0000, 5'd3, 5'd8, 5'd12);
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ex_valid); end
        checks++; if (ex_ctrl !== EXP_BUBBLE) begin errors++; $display("FAIL reset_ctrl got %h exp %h", ex_ctrl, EXP_BUBBLE); end
        checks++; if (ex_pc !== 32'h0 || ex_rs_data !== 32'h0 || ex_imm !== 32'h0) begin errors++; $display("FAIL reset_data got pc %h rs %h imm %h exp 0", ex_pc, ex_rs_data, ex_imm); end
        checks++; if (ex_dst !== 5'd0 || ex_rs_addr !== 5'd0 || ex_shamt !== 5'd0) begin errors++; $display("FAIL reset_addr got dst %0d rs %0d sh %0d exp 0", ex_dst, ex_rs_addr, ex_shamt); end
        checks++; if (halt !== 1'b0 || bubble_cnt !== 32'd0) begin errors++; $display("FAIL reset_halt_cnt got %0b %h exp 0 0", halt, bubble_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        do_reset();
        set_instr(1'b1, C_ADDI, 32'h100, 5'd3, 5'd8, 5'd12);
        tick();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b exp 1", ex_valid); end
        checks++; if (ex_ctrl !== 19'h28600) begin errors++; $display("FAIL addi_ctrl got %h exp 28600", ex_ctrl); end
        checks++; if (ex_dst !== 5'd8) begin errors++; $display("FAIL addi_dst got %0d exp 8", ex_dst); end
        checks++; if (ex_pc !== 32'h100 || ex_rs_data !== 32'h101 || ex_rt_data !== 32'h102 || ex_imm !== 32'h103) begin errors++; $display("FAIL addi_data got %h %h %h %h exp 100 101 102 103", ex_pc, ex_rs_data, ex_rt_data, ex_imm); end
        checks++; if (ex_rs_addr !== 5'd3 || ex_rt_addr !== 5'd8 || ex_shamt !== 5'd13) begin errors++; $display("FAIL addi_fields got %0d %0d %0d exp 3 8 13", ex_rs_addr, ex_rt_addr, ex_shamt); end
        set_instr(1'b1, C_ADD, 32'h104, 5'd1, 5'd2, 5'd7);
        tick();
        checks++; if (ex_dst !== 5'd7 || ex_pc !== 32'h104) begin errors++; $display("FAIL rtype_dst got %0d pc %h exp 7 104", ex_dst, ex_pc); end
        set_instr(1'b0, C_ADD, 32'h108, 5'd1, 5'd2, 5'd7);
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'h108) begin errors++; $display("FAIL invalid_load got %0b pc %h exp 0 108", ex_valid, ex_pc); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_instr(1'b1, C_LW, 32'h200, 5'd4, 5'd9, 5'd0);
        tick();
        checks++; if (ex_dst !== 5'd9) begin errors++; $display("FAIL lw_dst got %0d exp 9", ex_dst); end
        set_instr(1'b1, C_ADD, 32'h204, 5'd9, 5'd10, 5'd11);
        #1;
        checks++; if (load_use !== 1'b1) begin errors++; $display("FAIL lu_rs got %0b exp 1", load_use); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== EXP_BUBBLE || ex_pc !== 32'h0 || ex_dst !== 5'd0) begin errors++; $display("FAIL lu_bubble got v %0b ctrl %h pc %h dst %0d exp 0 68000 0 0", ex_valid, ex_ctrl, ex_pc, ex_dst); end
        checks++; if (load_use !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got %0b exp 0", load_use); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || ex_dst !== 5'd11) begin errors++; $display("FAIL lu_add_loaded got v %0b pc %h dst %0d exp 1 204 11", ex_valid, ex_pc, ex_dst); end
        checks++; if (bubble_cnt !== (CNT_EN ? 32'd1 : 32'd0)) begin errors++; $display("FAIL lu_cnt got %h exp %h", bubble_cnt, CNT_EN ? 32'd1 : 32'd0); end
        // rt match, gated by valid_in, and stall taking priority over the bubble
        set_instr(1'b1, C_LW, 32'h210, 5'd4, 5'd9, 5'd0);
        tick();
        set_instr(1'b0, C_ADD, 32'h214, 5'd1, 5'd9, 5'd3);
        #1;
        checks++; if (load_use !== 1'b0) begin errors++; $display("FAIL lu_id_invalid got %0b exp 0", load_use); end
        valid_in = 1'b1;
        #1;
        checks++; if (load_use !== 1'b1) begin errors++; $display("FAIL lu_rt got %0b exp 1", load_use); end
        stall = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h210 || load_use !== 1'b1) begin errors++; $display("FAIL lu_stall_hold got v %0b pc %h lu %0b exp 1 210 1", ex_valid, ex_pc, load_use); end
        stall = 1'b0;
    endtask

    task automatic test_stall_flush();
        do_reset();
        set_instr(1'b1, C_ADD, 32'h400, 5'd1, 5'd2, 5'd3);
        tick();
        set_instr(1'b1, C_ADD, 32'h404, 5'd1, 5'd2, 5'd4);
        stall = 1'b1; flush = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== EXP_BUBBLE || ex_pc !== 32'h0) begin errors++; $display("FAIL flush_over_stall got v %0b ctrl %h pc %h exp 0 68000 0", ex_valid, ex_ctrl, ex_pc); end
        stall = 1'b0; flush = 1'b0;
        set_instr(1'b1, C_ADD, 32'h408, 5'd1, 5'd2, 5'd5);
        tick();
        set_instr(1'b1, C_ADDI, 32'h40C, 5'd6, 5'd7, 5'd8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h408 || ex_dst !== 5'd5 || ex_ctrl !== C_ADD) begin errors++; $display("FAIL stall_hold%0d got v %0b pc %h dst %0d exp 1 408 5", i, ex_valid, ex_pc, ex_dst); end
        end
        stall = 1'b0;
        tick();
        checks++; if (ex_pc !== 32'h40C || ex_dst !== 5'd7) begin errors++; $display("FAIL stall_release got pc %h dst %0d exp 40c 7", ex_pc, ex_dst); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0 || ex_rt_data !== 32'h0) begin errors++; $display("FAIL flush_alone got v %0b rt %h exp 0 0", ex_valid, ex_rt_data); end
        checks++; if (bubble_cnt !== (CNT_EN ? 32'd2 : 32'd0)) begin errors++; $display("FAIL flush_cnt got %h exp %h", bubble_cnt, CNT_EN ? 32'd2 : 32'd0); end
    endtask

    task automatic test_jal_zero();
        do_reset();
        set_instr(1'b1, C_JAL, 32'h500, 5'd0, 5'd7, 5'd5);
        tick();
        checks++; if (ex_dst !== 5'd31 || ex_ctrl !== 19'h00202) begin errors++; $display("FAIL jal_dst got %0d ctrl %h exp 31 00202", ex_dst, ex_ctrl); end
        set_instr(1'b1, C_LW, 32'h504, 5'd2, 5'd0, 5'd0);
        tick();
        set_instr(1'b1, C_ADD, 32'h508, 5'd0, 5'd3, 5'd6);
        #1;
        checks++; if (load_use !== 1'b0) begin errors++; $display("FAIL lu_zero_dst got %0b exp 0", load_use); end
    endtask

    task automatic test_halt();
        do_reset();
        set_instr(1'b1, C_SYS, 32'h600, 5'd0, 5'd4, 5'd0);
        tick();
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_early got %0b exp 0", halt); end
        stall = 1'b1;
        set_instr(1'b1, C_ADD, 32'h604, 5'd4, 5'd5, 5'd6);
        tick();
        checks++; if (halt !== 1'b1 || ex_pc !== 32'h600) begin errors++; $display("FAIL halt_set got %0b pc %h exp 1 600", halt, ex_pc); end
        checks++; if (load_use !== 1'b0) begin errors++; $display("FAIL halt_lu_forced got %0b exp 0", load_use); end
        stall = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h600 || ex_ctrl !== C_SYS) begin errors++; $display("FAIL halt_flush_ignored got v %0b pc %h ctrl %h exp 1 600 01100", ex_valid, ex_pc, ex_ctrl); end
        checks++; if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL halt_no_count got %h exp 0", bubble_cnt); end
        set_instr(1'b1, C_ADDI, 32'h608, 5'd1, 5'd2, 5'd3);
        tick(); tick();
        checks++; if (halt !== 1'b1 || ex_pc !== 32'h600 || ex_dst !== 5'd4 || ex_imm !== 32'h603) begin errors++; $display("FAIL halt_frozen got h %0b pc %h dst %0d imm %h exp 1 600 4 603", halt, ex_pc, ex_dst, ex_imm); end
        rst_n = 1'b0;
        tick();
        checks++; if (halt !== 1'b0 || ex_valid !== 1'b0 || bubble_cnt !== 32'd0) begin errors++; $display("FAIL halt_reset got h %0b v %0b cnt %h exp 0 0 0", halt, ex_valid, bubble_cnt); end
        rst_n = 1'b1;
        set_instr(1'b1, C_ADD, 32'h700, 5'd1, 5'd2, 5'd3);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h700) begin errors++; $display("FAIL post_reset_load got v %0b pc %h exp 1 700", ex_valid, ex_pc); end
    endtask

    task automatic test_bubble_cnt();
        do_reset();
`ifdef ID_EX_BUBBLE_CNT_EN
        force dut.bubble_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt_q;
`endif
        flush = 1'b1;
        tick();
        checks++; if (bubble_cnt !== (CNT_EN ? 32'hFFFF_FFFF : 32'd0)) begin errors++; $display("FAIL cnt_step got %h exp %h", bubble_cnt, CNT_EN ? 32'hFFFF_FFFF : 32'd0); end
        tick();
        flush = 1'b0;
        checks++; if (bubble_cnt !== (CNT_EN ? 32'hFFFF_FFFF : 32'd0)) begin errors++; $display("FAIL cnt_saturate got %h exp %h", bubble_cnt, CNT_EN ? 32'hFFFF_FFFF : 32'd0); end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_instr(1'b0, 19'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_load();
        test_load_use();
        test_stall_flush();
        test_jal_zero();
        test_halt();
        test_bubble_cnt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: DW, 32, datapath width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 valid_in  in  1  ID slot holds a real instruction.
REQ-005 ctrl_in  in  19  decoder bundle: alu_op[3:0], mode[1:0], memtoreg, memwrite, alu_src, regwrite, syscall, signedext, regdst, beq, bne, jr, jmp, jal, shift (ctrl_t).
REQ-006 pc_in, rs_data, rt_data, imm_in  in  DW each  ID-stage PC, operands, extended immediate.
REQ-007 rs_addr, rt_addr, rd_addr, shamt  in  5 each  ID register fields and shift amount.
REQ-008 stall  in  1  external hold of ID/EX.
REQ-009 flush  in  1  branch/jump squash.
REQ-010 ex_valid  out  1  EX slot holds a real instruction.
REQ-011 ex_ctrl  out  19  registered ctrl_t.
REQ-012 ex_pc, ex_rs_data, ex_rt_data, ex_imm  out  DW each  registered data.
REQ-013 ex_rs_addr, ex_rt_addr, ex_dst, ex_shamt  out  5 each  registered fields; ex_dst = write register.
REQ-014 load_use  out  1  load-use hazard; upstream holds PC and IF/ID.
REQ-015 halt  out  1  sticky syscall halt.
REQ-016 bubble_cnt  out  32  inserted-bubble count.

Function
REQ-017 Per-cycle priority: reset > halt > flush > stall > load_use > load.
REQ-018 Load: all ex_* take inputs next edge, ex_valid <= valid_in; latency 1 cycle.
REQ-019 ex_dst at load: 31 if jal, else rd_addr if regdst, else rt_addr.
REQ-020 Bubble (flush, or load_use without stall): ex_valid=0, ex_ctrl=BUBBLE_CTRL (all flags 0, alu_op=13), data/address outputs 0.
REQ-021 stall=1 with flush=0: all ex_* hold; bubble_cnt unchanged.
REQ-022 load_use combinational from registered state: ex_valid & ex_ctrl.memtoreg & ex_dst!=0 & (ex_dst==rs_addr | ex_dst==rt_addr) & valid_in.
REQ-023 load_use lasts exactly one cycle per hazard: bubble clears ex_valid, deasserting it.
REQ-024 halt sets on the edge after a valid syscall sits in EX (ex_valid & ex_ctrl.syscall); sticky until reset.
REQ-025 halt=1: all ex_* frozen, flush/stall ignored, load_use forced 0.
REQ-026 flush and stall together: flush wins, bubble inserted.

Reset
REQ-027 rst_n=0 at edge: ex_valid=0, ex_ctrl=BUBBLE_CTRL, data/addresses 0, halt=0, bubble_cnt=0.
REQ-028 Reset mid-stall or mid-halt takes effect at that edge; next cycle resumes normal load.

Configuration
REQ-029 Macro ID_EX_BUBBLE_CNT_EN defined: bubble_cnt increments by 1 per inserted bubble edge (flush or load_use), saturating at 0xFFFFFFFF.
REQ-030 Macro absent: bubble_cnt tied to 0, no counter logic; port retained.

Structure
REQ-031 Shared package pipe_pkg holds ctrl_t layout, ALU_NOP=13, BUBBLE_CTRL, REG_RA=31.
REQ-032 Sub-module hazard_detect computes load_use; register and counter stay in id_ex_reg.

Verification
REQ-033 Load addi (alu_op=5, regwrite, alu_src), rt=8 -> next cycle ex_valid=1, ex_dst=8, ex_ctrl matches.
REQ-034 EX holds lw dst=9, ID add rs=9 -> load_use=1 one cycle, bubble (ex_valid=0, alu_op=13), then add loaded, bubble_cnt=1 if EN.
REQ-035 stall=1 and flush=1 same cycle -> bubble; stall alone 3 cycles -> outputs unchanged.
REQ-036 jal loaded with rd=5 -> ex_dst=31; lw dst=0 in EX, ID rs=0 -> load_use=0.
REQ-037 Valid syscall in EX -> halt=1 next edge, outputs frozen despite new inputs; rst_n=0 -> halt=0, bubble_cnt=0.
REQ-038 0xFFFFFFFE preloaded via force, two flushes -> bubble_cnt=0xFFFFFFFF held; EN undefined -> always 0.
